// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntt_stage_sequencer: butterfly address/twiddle sequencer for an in-place   |
// | radix-2 DIF NTT, N = 2^(cfg+3). Optional macro: NTT_SEQ_STALL_CNT_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ntt_stage_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic              clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [2:0]        i_point_configuration,
  output logic              o_busy,
  output logic              o_working,
  output logic [2:0]        o_point_configuration,
  output logic              o_bf_valid,
  input  logic              i_bf_ready,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic [ADDR_W-2:0] o_twiddle_idx,
  output logic [3:0]        o_stage,
  output logic              o_last_in_stage,
  output logic              o_stage_done,
`ifdef NTT_SEQ_STALL_CNT_EN
  output logic [15:0]       o_stall_count,
`endif
  output logic              o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int GW = ADDR_W - 1;
  // A zero-length drain still spends one cycle in DRAIN to emit the stage pulse.
  localparam int DRAIN_LEN = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES : 1;
  localparam int DCNT_W    = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_LEN - 1);
  localparam int CFG_MAX_I = (ADDR_W - 3 > 7) ? 7 : ADDR_W - 3;
  localparam logic [2:0] CFG_MAX = 3'(CFG_MAX_I);

  state_t            state_q, state_d;
  logic [2:0]        cfg_q, cfg_d;
  logic [3:0]        stage_q, stage_d;
  logic [GW-1:0]     g_q, g_d;
  logic [GW-1:0]     j_q, j_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  logic [3:0]        log_n_w;
  logic [3:0]        shift_w;
  logic [ADDR_W-1:0] stride_w;
  logic [ADDR_W-1:0] grp_last_w;
  logic [ADDR_W-1:0] addr_a_w;
  logic              j_last_w;
  logic              g_last_w;
  logic              stage_last_w;
  logic              drain_end_w;
  logic              issue_w;
  logic [2:0]        cfg_sat_w;

  // stride = N >> (s+1) = 1 << (log2N - 1 - s); group base = g * 2 * stride.
  always_comb begin
    log_n_w      = {1'b0, cfg_q} + 4'd3;
    shift_w      = log_n_w - 4'd1 - stage_q;
    stride_w     = ADDR_W'(1) << shift_w;
    grp_last_w   = (ADDR_W'(1) << stage_q) - ADDR_W'(1);
    j_last_w     = ({1'b0, j_q} == (stride_w - ADDR_W'(1)));
    g_last_w     = ({1'b0, g_q} == grp_last_w);
    stage_last_w = (stage_q == (log_n_w - 4'd1));
    addr_a_w     = ({1'b0, g_q} << (shift_w + 4'd1)) + {1'b0, j_q};
    drain_end_w  = (state_q == ST_DRAIN) && (dcnt_q == DRAIN_LAST);
    issue_w      = (state_q == ST_ISSUE);
    cfg_sat_w    = (i_point_configuration > CFG_MAX) ? CFG_MAX : i_point_configuration;
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    stage_d = stage_q;
    g_d     = g_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ISSUE;
          cfg_d   = cfg_sat_w;
          stage_d = 4'd0;
          g_d     = '0;
          j_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (i_bf_ready) begin
          if (j_last_w) begin
            j_d = '0;
            if (g_last_w) begin
              g_d     = '0;
              dcnt_d  = '0;
              state_d = ST_DRAIN;
            end else begin
              g_d = g_q + GW'(1);
            end
          end else begin
            j_d = j_q + GW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          dcnt_d = '0;
          if (stage_last_w) begin
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q + 4'd1;
            g_d     = '0;
            j_d     = '0;
            state_d = ST_ISSUE;
          end
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      state_q <= ST_IDLE;
      cfg_q   <= 3'd0;
      stage_q <= 4'd0;
      g_q     <= '0;
      j_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      stage_q <= stage_d;
      g_q     <= g_d;
      j_q     <= j_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign o_busy                = (state_q != ST_IDLE);
  assign o_working             = o_busy;
  assign o_point_configuration = cfg_q;
  assign o_bf_valid            = issue_w;
  assign o_addr_a              = issue_w ? addr_a_w : '0;
  assign o_addr_b              = issue_w ? (addr_a_w + stride_w) : '0;
  assign o_twiddle_idx         = issue_w ? (j_q << stage_q) : '0;
  assign o_stage               = stage_q;
  assign o_last_in_stage       = issue_w && j_last_w && g_last_w;
  assign o_stage_done          = drain_end_w;
  assign o_done                = (state_q == ST_DONE);

`ifdef NTT_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && i_start) begin
      stall_d = 16'd0;
    end else if (issue_w && !i_bf_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_count = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// Directed self-checking bench for ntt_stage_sequencer (DRAIN_CYCLES=6 and 0).
module tb_ntt_stage_sequencer;

  logic       clk = 1'b0;
  logic       i_resetn;
  logic       i_start;
  logic [2:0] i_point_configuration;
  logic       i_bf_ready;
  logic       o_busy, o_working, o_bf_valid, o_last_in_stage, o_stage_done, o_done;
  logic [2:0] o_point_configuration;
  logic [9:0] o_addr_a, o_addr_b;
  logic [8:0] o_twiddle_idx;
  logic [3:0] o_stage;

  logic       s0_start;
  logic [2:0] s0_cfg;
  logic       s0_ready;
  logic       z_busy, z_working, z_valid, z_last, z_sd, z_done;
  logic [2:0] z_cfg;
  logic [9:0] z_a, z_b;
  logic [8:0] z_tw;
  logic [3:0] z_stage;

`ifdef NTT_SEQ_STALL_CNT_EN
  logic [15:0] o_stall_count;
  logic [15:0] z_stall;
`endif

  always #5 clk = ~clk;

  ntt_stage_sequencer #(.ADDR_W(10), .DRAIN_CYCLES(6)) dut (
    .clk(clk), .i_resetn(i_resetn), .i_start(i_start),
    .i_point_configuration(i_point_configuration),
    .o_busy(o_busy), .o_working(o_working),
    .o_point_configuration(o_point_configuration),
    .o_bf_valid(o_bf_valid), .i_bf_ready(i_bf_ready),
    .o_addr_a(o_addr_a), .o_addr_b(o_addr_b), .o_twiddle_idx(o_twiddle_idx),
    .o_stage(o_stage), .o_last_in_stage(o_last_in_stage),
    .o_stage_done(o_stage_done),
`ifdef NTT_SEQ_STALL_CNT_EN
    .o_stall_count(o_stall_count),
`endif
    .o_done(o_done)
  );

  ntt_stage_sequencer #(.ADDR_W(10), .DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .i_resetn(i_resetn), .i_start(s0_start),
    .i_point_configuration(s0_cfg),
    .o_busy(z_busy), .o_working(z_working),
    .o_point_configuration(z_cfg),
    .o_bf_valid(z_valid), .i_bf_ready(s0_ready),
    .o_addr_a(z_a), .o_addr_b(z_b), .o_twiddle_idx(z_tw),
    .o_stage(z_stage), .o_last_in_stage(z_last),
    .o_stage_done(z_sd),
`ifdef NTT_SEQ_STALL_CNT_EN
    .o_stall_count(z_stall),
`endif
    .o_done(z_done)
  );

  int errors = 0;
  int checks = 0;

  int q_a[$];
  int q_b[$];
  int q_tw[$];
  int n_sd, n_last, done_cyc, held_cnt, n_hs;
  logic busy_at_done;

  int exp_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int exp_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int exp_tw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

  // Runs one transform on dut; stalls pair index 1 for stall_cycles cycles,
  // pulses i_start with a new cfg at cycle 'poke'. Cycle 0 is the start cycle.
  task automatic run_xfer(input int cfg, input int stall_cycles, input int poke,
                          input int budget);
    int stall_left;
    q_a.delete(); q_b.delete(); q_tw.delete();
    n_sd = 0; n_last = 0; done_cyc = -1; held_cnt = 0; n_hs = 0;
    busy_at_done = 1'b0;
    stall_left = stall_cycles;
    i_point_configuration = cfg[2:0];
    i_bf_ready = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= budget; c++) begin
      if (c == poke) begin
        i_start = 1'b1;
        i_point_configuration = 3'd3;
      end else begin
        i_start = 1'b0;
      end
      i_bf_ready = 1'b1;
      if (o_bf_valid && n_hs == 1 && stall_left > 0) begin
        i_bf_ready = 1'b0;
        stall_left--;
      end
      if (o_bf_valid && o_addr_a == 10'd1 && o_addr_b == 10'd5) held_cnt++;
      if (o_bf_valid && i_bf_ready) begin
        q_a.push_back(int'(o_addr_a));
        q_b.push_back(int'(o_addr_b));
        q_tw.push_back(int'(o_twiddle_idx));
        n_hs++;
        if (o_last_in_stage) n_last++;
      end
      if (o_stage_done) n_sd++;
      if (o_done) begin
        done_cyc = c;
        busy_at_done = o_busy;
        break;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_resetn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({o_busy, o_working, o_bf_valid, o_last_in_stage, o_stage_done, o_done} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=000000",
        {o_busy, o_working, o_bf_valid, o_last_in_stage, o_stage_done, o_done});
    end
    checks++;
    if ({o_addr_a, o_addr_b, o_twiddle_idx, o_stage, o_point_configuration} !== 36'd0) begin
      errors++; $display("FAIL reset_values a=%0d b=%0d tw=%0d stage=%0d cfg=%0d want all 0",
        o_addr_a, o_addr_b, o_twiddle_idx, o_stage, o_point_configuration);
    end
`ifdef NTT_SEQ_STALL_CNT_EN
    checks++;
    if (o_stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_stall got=%0d want=0", o_stall_count);
    end
`endif
    i_resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_n8();
    run_xfer(0, 0, -1, 100);
    checks++;
    if (n_hs !== 12) begin errors++; $display("FAIL n8_handshakes got=%0d want=12", n_hs); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (q_a[i] !== exp_a[i] || q_b[i] !== exp_b[i] || q_tw[i] !== exp_tw[i]) begin
        errors++;
        $display("FAIL n8_pair%0d got=(%0d,%0d,tw%0d) want=(%0d,%0d,tw%0d)",
                 i, q_a[i], q_b[i], q_tw[i], exp_a[i], exp_b[i], exp_tw[i]);
      end
    end
    checks++;
    if (n_sd !== 3) begin errors++; $display("FAIL n8_stage_done got=%0d want=3", n_sd); end
    checks++;
    if (done_cyc !== 31) begin errors++; $display("FAIL n8_done_cycle got=%0d want=31", done_cyc); end
    checks++;
    if (busy_at_done !== 1'b1) begin errors++; $display("FAIL n8_busy_at_done got=%b want=1", busy_at_done); end
    checks++;
    if (n_last !== 3) begin errors++; $display("FAIL n8_last got=%0d want=3", n_last); end
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL n8_idle_after busy=%b done=%b want 0,0", o_busy, o_done);
    end
  endtask

  task automatic test_n1024();
    run_xfer(7, 0, -1, 6000);
    checks++;
    if (n_hs !== 5120) begin errors++; $display("FAIL n1024_handshakes got=%0d want=5120", n_hs); end
    checks++;
    if (n_sd !== 10) begin errors++; $display("FAIL n1024_stage_done got=%0d want=10", n_sd); end
    checks++;
    if (n_last !== 10) begin errors++; $display("FAIL n1024_last got=%0d want=10", n_last); end
    checks++;
    if (done_cyc !== 5181) begin errors++; $display("FAIL n1024_done_cycle got=%0d want=5181", done_cyc); end
    checks++;
    if (q_a[0] !== 0 || q_b[0] !== 512 || q_tw[0] !== 0) begin
      errors++; $display("FAIL n1024_first got=(%0d,%0d,tw%0d) want=(0,512,tw0)", q_a[0], q_b[0], q_tw[0]);
    end
    checks++;
    if (q_a[513] !== 1 || q_b[513] !== 257 || q_tw[513] !== 2) begin
      errors++; $display("FAIL n1024_s1p1 got=(%0d,%0d,tw%0d) want=(1,257,tw2)", q_a[513], q_b[513], q_tw[513]);
    end
    checks++;
    if (q_a[5119] !== 1022 || q_b[5119] !== 1023 || q_tw[5119] !== 0) begin
      errors++; $display("FAIL n1024_final got=(%0d,%0d,tw%0d) want=(1022,1023,tw0)", q_a[5119], q_b[5119], q_tw[5119]);
    end
    checks++;
    if (o_point_configuration !== 3'd7) begin
      errors++; $display("FAIL n1024_cfg got=%0d want=7", o_point_configuration);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    run_xfer(0, 3, -1, 100);
    checks++;
    if (held_cnt !== 4) begin errors++; $display("FAIL bp_held_cycles got=%0d want=4", held_cnt); end
    checks++;
    if (q_a[1] !== 1 || q_b[1] !== 5 || q_tw[1] !== 1) begin
      errors++; $display("FAIL bp_pair1 got=(%0d,%0d,tw%0d) want=(1,5,tw1)", q_a[1], q_b[1], q_tw[1]);
    end
    checks++;
    if (n_hs !== 12) begin errors++; $display("FAIL bp_handshakes got=%0d want=12", n_hs); end
    checks++;
    if (done_cyc !== 34) begin errors++; $display("FAIL bp_done_cycle got=%0d want=34", done_cyc); end
`ifdef NTT_SEQ_STALL_CNT_EN
    checks++;
    if (o_stall_count !== 16'd3) begin errors++; $display("FAIL bp_stall_count got=%0d want=3", o_stall_count); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int c;
    i_point_configuration = 3'd0;
    i_bf_ready = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    c = 1;
    while (!(o_bf_valid && o_stage == 4'd1) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c !== 11) begin errors++; $display("FAIL rmid_stage1_cycle got=%0d want=11", c); end
    i_resetn = 1'b0;
    @(posedge clk); #1;
    i_resetn = 1'b1;
    checks++;
    if (o_busy !== 1'b0 || o_bf_valid !== 1'b0 || o_stage !== 4'd0) begin
      errors++; $display("FAIL rmid_after_reset busy=%b valid=%b stage=%0d want 0,0,0",
                         o_busy, o_bf_valid, o_stage);
    end
    run_xfer(0, 0, -1, 100);
    checks++;
    if (q_a[0] !== 0 || q_b[0] !== 4) begin
      errors++; $display("FAIL rmid_restart_pair got=(%0d,%0d) want=(0,4)", q_a[0], q_b[0]);
    end
    checks++;
    if (done_cyc !== 31) begin errors++; $display("FAIL rmid_done_cycle got=%0d want=31", done_cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int extra_done;
    run_xfer(0, 0, 6, 100);
    checks++;
    if (done_cyc !== 31) begin errors++; $display("FAIL ign_done_cycle got=%0d want=31", done_cyc); end
    checks++;
    if (n_hs !== 12) begin errors++; $display("FAIL ign_handshakes got=%0d want=12", n_hs); end
    checks++;
    if (q_a[11] !== 6 || q_b[11] !== 7 || q_a[4] !== 0 || q_b[4] !== 2) begin
      errors++; $display("FAIL ign_addrs got=(%0d,%0d)/(%0d,%0d) want=(6,7)/(0,2)",
                         q_a[11], q_b[11], q_a[4], q_b[4]);
    end
    checks++;
    if (o_point_configuration !== 3'd0) begin
      errors++; $display("FAIL ign_cfg got=%0d want=0", o_point_configuration);
    end
    extra_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_done || o_busy) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin errors++; $display("FAIL ign_single_done got=%0d extra busy/done cycles want=0", extra_done); end
  endtask

  task automatic test_drain0();
    int c, sd, hs, first_sd, dc;
    sd = 0; hs = 0; first_sd = -1; dc = -1;
    s0_cfg = 3'd0;
    s0_ready = 1'b1;
    s0_start = 1'b1;
    @(posedge clk); #1;
    s0_start = 1'b0;
    for (c = 1; c <= 60; c++) begin
      if (z_valid && s0_ready) hs++;
      if (z_sd) begin
        sd++;
        if (first_sd < 0) first_sd = c;
      end
      if (z_done) begin dc = c; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (dc !== 16) begin errors++; $display("FAIL d0_done_cycle got=%0d want=16", dc); end
    checks++;
    if (sd !== 3) begin errors++; $display("FAIL d0_stage_done got=%0d want=3", sd); end
    checks++;
    if (first_sd !== 5) begin errors++; $display("FAIL d0_first_stage_done got=%0d want=5", first_sd); end
    checks++;
    if (hs !== 12) begin errors++; $display("FAIL d0_handshakes got=%0d want=12", hs); end
    @(posedge clk); #1;
  endtask

  initial begin
    i_resetn = 1'b0;
    i_start = 1'b0;
    i_point_configuration = 3'd0;
    i_bf_ready = 1'b1;
    s0_start = 1'b0;
    s0_cfg = 3'd0;
    s0_ready = 1'b1;
    #1;
    test_reset();
    test_n8();
    test_n1024();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_drain0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
- Sequences butterfly operations for one in-place radix-2 NTT (decimation-in-frequency, stride halving per stage) over a 2^(cfg+3)-point buffer, N = 8..1024.
- Per cycle it issues an operand address pair and a twiddle index to the butterfly datapath over a valid/ready handshake.
- It inserts a pipeline-drain gap between stages and reports stage boundaries and completion.
- It drives point_config's i_working and i_point_configuration, so stride and group settings stay coherent with the active transform.

Parameters:
- ADDR_W, 10, buffer address width; max N = 2^ADDR_W.
- DRAIN_CYCLES, 6, idle cycles after each stage's last issue; matches datapath DELAY; 0 allowed.

Ports:
- clk  in  1  clock.
- i_resetn  in  1  reset; synchronous, active-low.
- i_start  in  1  start request; sampled only in IDLE.
- i_point_configuration  in  3  size select, N = 2^(cfg+3); latched on start.
- o_busy  out  1  high from start accept until DONE inclusive.
- o_working  out  1  to point_config; equals o_busy.
- o_point_configuration  out  3  latched cfg.
- o_bf_valid  out  1  address pair valid.
- i_bf_ready  in  1  datapath accepts pair.
- o_addr_a  out  ADDR_W  lower operand address.
- o_addr_b  out  ADDR_W  o_addr_a + stride.
- o_twiddle_idx  out  ADDR_W-1  twiddle table index.
- o_stage  out  4  current stage, 0..log2N-1.
- o_last_in_stage  out  1  the current pair is the stage's final one.
- o_stage_done  out  1  one-cycle pulse when a stage's drain completes.
- o_done  out  1  one-cycle pulse at transform completion.

Behaviour:
- Reset: i_resetn=0 at posedge forces IDLE; all outputs 0; latched cfg 0. Applies mid-operation; no pending issue survives.
- Definitions:
  - L = cfg+3.
  - Stage s in 0..L-1.
  - stride = N >> (s+1).
  - groups = 2^s.
  - Butterflies per group = stride.
  - Group g, index j: addr_a = g*2*stride + j; addr_b = addr_a + stride; twiddle = j << s.
  - Issue order: j innermost, then g.
  - Each stage issues N/2 pairs.
- cfg values above ADDR_W-3 saturate to ADDR_W-3.
- FSM states:
  - IDLE: i_start=1 latches cfg and sets s=0, g=0, j=0; next state ISSUE. Otherwise stay.
  - ISSUE: o_bf_valid=1. On a handshake (valid & ready), advance j. When j wraps, advance g. On the last pair of the stage, go to DRAIN. Without ready, all outputs hold stable (no glitch, no advance).
  - DRAIN: o_bf_valid=0; count DRAIN_CYCLES cycles.
    - Final drain cycle: pulse o_stage_done.
    - If s < L-1: s+1, clear g and j, go to ISSUE.
    - Else: go to DONE.
    - DRAIN_CYCLES=0: DRAIN lasts one cycle.
  - DONE: o_done=1 and o_busy=1 for one cycle; next state IDLE.
- Timing: start accepted at cycle t gives first o_bf_valid at t+1. With ready held high and DRAIN_CYCLES=D, o_done occurs at t+1+L*(N/2+max(D,1)).
- i_start in any non-IDLE state is ignored.
- Changes on i_point_configuration while busy are ignored.
- All arithmetic is unsigned. Address sums never exceed N-1; no wrap.

Optional Feature:
- Macro: NTT_SEQ_STALL_CNT_EN.
- With macro: adds port o_stall_count (out, 16). It counts ISSUE cycles with o_bf_valid & ~i_bf_ready, saturates at 16'hFFFF, clears on start accept, and resets to 0.
- Without macro: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- N=8, cfg=0, ready=1, D=6, start at t:
  - Stage 0 pairs (0,4)(1,5)(2,6)(3,7), twiddles 0,1,2,3.
  - Stage 1 pairs (0,2)(1,3)(4,6)(5,7), twiddles 0,2,0,2.
  - Stage 2 pairs (0,1)(2,3)(4,5)(6,7), twiddles 0.
  - o_stage_done pulses 3 times; o_done at t+31.
- N=1024, cfg=7, ready=1: 5120 handshakes, 10 o_stage_done pulses, o_done at t+1+10*518 = t+5181, o_last_in_stage exactly 10 times.
- Backpressure, N=8: ready low for 3 cycles on the 2nd pair → pair (1,5) held stable 4 cycles. o_done is delayed by 3 cycles. o_stall_count=3 with NTT_SEQ_STALL_CNT_EN.
- Reset mid-stage 1 (i_resetn low for 1 cycle): next cycle IDLE, o_busy=0, o_bf_valid=0. A new start restarts at stage 0, pair (0,4).
- i_start pulsed while busy, and cfg changed during the run: no restart; addresses follow the latched cfg; a single o_done.
- D=0, N=8: each DRAIN lasts 1 cycle; o_done at t+1+3*5 = t+16.
